// File: rtl/avalon_st_packet_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : avalon_st_packet_fifo
//  Description : Single-clock Avalon-ST packet FIFO with sop/eop sideband,
//                fill/packet counters, almost-full/almost-empty flags and an
//                optional store-and-forward mode with oversize fallback.
//  Revision    : 1.0 - initial release
// ============================================================================
module avalon_st_packet_fifo #(
   parameter int DATA_WIDTH             = 42,
   parameter int DEPTH                  = 16,
   parameter int ADDR_WIDTH             = 4,
   parameter int ALMOST_FULL_THRESHOLD  = 12,
   parameter int ALMOST_EMPTY_THRESHOLD = 2,
   parameter int STORE_AND_FORWARD      = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   input  logic                  in_startofpacket,
   input  logic                  in_endofpacket,
   output logic                  in_ready,
   output logic [DATA_WIDTH-1:0] out_data,
   output logic                  out_valid,
   output logic                  out_startofpacket,
   output logic                  out_endofpacket,
   input  logic                  out_ready,
   output logic [ADDR_WIDTH:0]   fill_level,
   output logic [ADDR_WIDTH:0]   pkt_count,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  oversize
);

   localparam int                ENTRY_WIDTH = DATA_WIDTH + 2;
   localparam logic [ADDR_WIDTH:0] FULL_LEVEL = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0] AF_LEVEL   = (ADDR_WIDTH+1)'(ALMOST_FULL_THRESHOLD);
   localparam logic [ADDR_WIDTH:0] AE_LEVEL   = (ADDR_WIDTH+1)'(ALMOST_EMPTY_THRESHOLD);

   logic [ENTRY_WIDTH-1:0] mem [DEPTH];
   logic [ENTRY_WIDTH-1:0] head;
   logic [ADDR_WIDTH-1:0]  wr_ptr;
   logic [ADDR_WIDTH-1:0]  rd_ptr;
   logic [ADDR_WIDTH-1:0]  rd_next;
   logic                   push;
   logic                   pop;
   logic                   push_eop;
   logic                   pop_eop;
   logic [ADDR_WIDTH:0]    fill_after_pop;
   logic [ADDR_WIDTH:0]    fill_next;
   logic [ADDR_WIDTH:0]    pkt_after_pop;
   logic [ADDR_WIDTH:0]    pkt_next;
   logic                   release_ok;
   logic                   oversize_cond;
   logic                   next_out_valid;

   // Handshakes; in_ready comes from registered state only, so a full FIFO
   // never accepts a beat even when the head is being popped.
   assign in_ready = (fill_level != FULL_LEVEL);
   assign push     = in_valid & in_ready;
   assign pop      = out_valid & out_ready;
   assign push_eop = push & in_endofpacket;
   assign pop_eop  = pop & out_endofpacket;

   // Look-ahead read address so consecutive pops stream one beat per cycle.
   assign rd_next = rd_ptr + {{(ADDR_WIDTH-1){1'b0}}, pop};

   assign fill_after_pop = fill_level - {{ADDR_WIDTH{1'b0}}, pop};
   assign fill_next      = fill_after_pop + {{ADDR_WIDTH{1'b0}}, push};
   assign pkt_after_pop  = pkt_count - {{ADDR_WIDTH{1'b0}}, pop_eop};
   assign pkt_next       = pkt_after_pop + {{ADDR_WIDTH{1'b0}}, push_eop};

   generate
      if (STORE_AND_FORWARD != 0) begin : g_saf
         logic draining;
         logic draining_next;

         // A full FIFO with no complete packet can never see its eop, so the
         // packet is released cut-through instead of deadlocking.
         assign oversize_cond = (fill_level == FULL_LEVEL) && (pkt_count == '0) && !draining;
         assign draining_next = (draining | oversize_cond) & ~pop_eop;
         assign release_ok    = (pkt_after_pop != '0) | draining_next;

         // Draining flag: held from the oversize event until that packet's eop leaves.
         always_ff @(posedge clk or negedge reset_n) begin
            if (!reset_n) begin
               draining <= 1'b0;
            end else begin
               draining <= draining_next;
            end
         end
      end else begin : g_ct
         assign oversize_cond = 1'b0;
         assign release_ok    = 1'b1;
      end
   endgenerate

   // A beat written on this edge is not readable from the RAM until the next
   // edge, so validity is based on the occupancy left after this cycle's pop.
   assign next_out_valid = (fill_after_pop != '0) & release_ok;

   // Control state: pointers, counters, output valid and the oversize pulse.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fill_level <= '0;
         pkt_count  <= '0;
         out_valid  <= 1'b0;
         oversize   <= 1'b0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
         end
         rd_ptr     <= rd_next;
         fill_level <= fill_next;
         pkt_count  <= pkt_next;
         out_valid  <= next_out_valid;
         oversize   <= oversize_cond;
      end
   end

   // Storage write and registered head read; contents need no reset.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= {in_startofpacket, in_endofpacket, in_data};
      end
      head <= mem[rd_next];
   end

   assign out_data          = head[DATA_WIDTH-1:0];
   assign out_endofpacket   = head[DATA_WIDTH];
   assign out_startofpacket = head[DATA_WIDTH+1];

   assign almost_full  = (fill_level >= AF_LEVEL);
   assign almost_empty = (fill_level <= AE_LEVEL);

endmodule
`default_nettype wire

// File: tb/tb_avalon_st_packet_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_avalon_st_packet_fifo
//  Description : Directed and randomised checks for avalon_st_packet_fifo in
//                cut-through and store-and-forward configurations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_avalon_st_packet_fifo;

   localparam int DW = 42;
   localparam int AW = 4;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;

   // cut-through instance signals
   logic [DW-1:0] c_in_data = '0;
   logic          c_in_valid = 1'b0, c_in_sop = 1'b0, c_in_eop = 1'b0, c_in_ready;
   logic [DW-1:0] c_out_data;
   logic          c_out_valid, c_out_sop, c_out_eop, c_out_ready = 1'b0;
   logic [AW:0]   c_fill_level, c_pkt_count;
   logic          c_almost_full, c_almost_empty, c_oversize;

   // store-and-forward instance signals
   logic [DW-1:0] s_in_data = '0;
   logic          s_in_valid = 1'b0, s_in_sop = 1'b0, s_in_eop = 1'b0, s_in_ready;
   logic [DW-1:0] s_out_data;
   logic          s_out_valid, s_out_sop, s_out_eop, s_out_ready = 1'b0;
   logic [AW:0]   s_fill_level, s_pkt_count;
   logic          s_almost_full, s_almost_empty, s_oversize;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   avalon_st_packet_fifo #(
      .DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(AW),
      .ALMOST_FULL_THRESHOLD(12), .ALMOST_EMPTY_THRESHOLD(2), .STORE_AND_FORWARD(0)
   ) dut_ct (
      .clk(clk), .reset_n(reset_n),
      .in_data(c_in_data), .in_valid(c_in_valid),
      .in_startofpacket(c_in_sop), .in_endofpacket(c_in_eop), .in_ready(c_in_ready),
      .out_data(c_out_data), .out_valid(c_out_valid),
      .out_startofpacket(c_out_sop), .out_endofpacket(c_out_eop), .out_ready(c_out_ready),
      .fill_level(c_fill_level), .pkt_count(c_pkt_count),
      .almost_full(c_almost_full), .almost_empty(c_almost_empty), .oversize(c_oversize)
   );

   avalon_st_packet_fifo #(
      .DATA_WIDTH(DW), .DEPTH(16), .ADDR_WIDTH(AW),
      .ALMOST_FULL_THRESHOLD(12), .ALMOST_EMPTY_THRESHOLD(2), .STORE_AND_FORWARD(1)
   ) dut_saf (
      .clk(clk), .reset_n(reset_n),
      .in_data(s_in_data), .in_valid(s_in_valid),
      .in_startofpacket(s_in_sop), .in_endofpacket(s_in_eop), .in_ready(s_in_ready),
      .out_data(s_out_data), .out_valid(s_out_valid),
      .out_startofpacket(s_out_sop), .out_endofpacket(s_out_eop), .out_ready(s_out_ready),
      .fill_level(s_fill_level), .pkt_count(s_pkt_count),
      .almost_full(s_almost_full), .almost_empty(s_almost_empty), .oversize(s_oversize)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // random-phase model state
   logic [DW+1:0] q[$];
   logic [DW+1:0] front;
   logic [DW-1:0] cur_data;
   int            beats_left;
   bit            first_beat;
   int            model_cnt;
   bit            do_push, do_pop;

   initial begin
      // ---------------- reset ----------------
      repeat (3) @(posedge clk);
      #1;
      reset_n = 1'b1;
      chk("rst_in_ready",     c_in_ready, 1);
      chk("rst_fill",         c_fill_level, 0);
      chk("rst_pkt",          c_pkt_count, 0);
      chk("rst_out_valid",    c_out_valid, 0);
      chk("rst_almost_empty", c_almost_empty, 1);
      chk("rst_almost_full",  c_almost_full, 0);
      chk("rst_oversize",     c_oversize, 0);
      chk("rst_saf_valid",    s_out_valid, 0);
      chk("rst_saf_ready",    s_in_ready, 1);
      step();

      // ---------------- latency ----------------
      c_in_valid = 1; c_in_data = 42'h0AA; c_in_sop = 1; c_in_eop = 1;
      step();                                  // push edge k
      c_in_valid = 0; c_in_sop = 0; c_in_eop = 0;
      chk("lat_valid_k",  c_out_valid, 0);
      chk("lat_fill_k",   c_fill_level, 1);
      chk("lat_pkt_k",    c_pkt_count, 1);
      step();                                  // edge k+1
      chk("lat_valid_k1", c_out_valid, 1);
      chk("lat_data",     c_out_data, 42'h0AA);
      chk("lat_sop",      c_out_sop, 1);
      chk("lat_eop",      c_out_eop, 1);
      c_out_ready = 1;
      step();                                  // pop edge
      c_out_ready = 0;
      chk("lat_valid_pop", c_out_valid, 0);
      chk("lat_fill_pop",  c_fill_level, 0);
      chk("lat_pkt_pop",   c_pkt_count, 0);

      // ---------------- fill to full ----------------
      for (int i = 0; i < 16; i++) begin
         c_in_valid = 1; c_in_data = DW'(i); c_in_sop = (i == 0); c_in_eop = (i == 15);
         step();
         if (i == 1)  chk("ae_at_2",  c_almost_empty, 1);
         if (i == 2)  chk("ae_at_3",  c_almost_empty, 0);
         if (i == 10) chk("af_at_11", c_almost_full, 0);
         if (i == 11) chk("af_at_12", c_almost_full, 1);
      end
      chk("full_in_ready", c_in_ready, 0);
      chk("full_fill",     c_fill_level, 16);
      chk("full_af",       c_almost_full, 1);
      chk("full_pkt",      c_pkt_count, 1);
      chk("full_head",     c_out_data, 0);
      c_in_data = 42'h099; c_in_sop = 0; c_in_eop = 0;
      step();                                  // 17th offer
      chk("full_no_push",  c_fill_level, 16);

      // ---------------- simultaneous push/pop ----------------
      c_in_data = 42'h010; c_out_ready = 1;
      step();                                  // pop only (in_ready was 0)
      chk("sim_fill_pop",  c_fill_level, 15);
      chk("sim_head1",     c_out_data, 1);
      step();                                  // push 0x10 and pop 1 together
      c_in_valid = 0;
      chk("sim_fill_both", c_fill_level, 15);
      for (int j = 2; j <= 16; j++) begin
         chk("drain_valid", c_out_valid, 1);
         chk("drain_data",  c_out_data, 64'(j));
         chk("drain_fill",  c_fill_level, 64'(17 - j));
         step();
      end
      c_out_ready = 0;
      chk("drain_end_valid", c_out_valid, 0);
      chk("drain_end_fill",  c_fill_level, 0);
      chk("drain_end_pkt",   c_pkt_count, 0);

      // ---------------- random cut-through ----------------
      beats_left = 0; first_beat = 0; model_cnt = 0;
      cur_data = {10'($urandom), $urandom};
      for (int cyc = 0; cyc < 400; cyc++) begin
         chk("rand_fill", c_fill_level, 64'(model_cnt));
         if (beats_left == 0) begin
            beats_left = $urandom_range(1, 20);
            first_beat = 1;
         end
         c_in_valid  = $urandom_range(0, 1);
         c_in_data   = cur_data;
         c_in_sop    = first_beat;
         c_in_eop    = (beats_left == 1);
         c_out_ready = $urandom_range(0, 1);
         #1;
         do_pop  = c_out_valid & c_out_ready;
         do_push = c_in_valid & c_in_ready;
         if (do_pop) begin
            chk("rand_nonempty", 64'(q.size() > 0), 1);
            if (q.size() > 0) begin
               front = q.pop_front();
               chk("rand_beat", {c_out_sop, c_out_eop, c_out_data}, front);
               model_cnt--;
            end
         end
         if (do_push) begin
            q.push_back({c_in_sop, c_in_eop, c_in_data});
            model_cnt++;
            beats_left--;
            first_beat = 0;
            cur_data = {10'($urandom), $urandom};
         end
         step();
      end
      c_in_valid = 0; c_out_ready = 1;
      for (int cyc = 0; cyc < 60 && q.size() > 0; cyc++) begin
         if (c_out_valid) begin
            front = q.pop_front();
            chk("rand_tail_beat", {c_out_sop, c_out_eop, c_out_data}, front);
         end
         step();
      end
      c_out_ready = 0;
      chk("rand_queue_empty", 64'(q.size()), 0);
      chk("rand_end_fill",    c_fill_level, 0);
      chk("ct_no_oversize",   c_oversize, 0);

      // ---------------- store-and-forward: held packet ----------------
      s_out_ready = 1;
      for (int i = 0; i < 4; i++) begin
         s_in_valid = 1; s_in_data = DW'(12'h100 + i); s_in_sop = (i == 0); s_in_eop = 0;
         step();
         chk("saf_hold_beat", s_out_valid, 0);
      end
      s_in_valid = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("saf_hold_gap", s_out_valid, 0);
      end
      s_in_valid = 1; s_in_data = 42'h104; s_in_sop = 0; s_in_eop = 1;
      step();                                  // eop push edge
      s_in_valid = 0; s_in_eop = 0;
      chk("saf_hold_eop", s_out_valid, 0);
      chk("saf_pkt1",     s_pkt_count, 1);
      step();
      for (int i = 0; i < 5; i++) begin
         chk("saf_valid", s_out_valid, 1);
         chk("saf_data",  s_out_data, 64'(12'h100 + i));
         chk("saf_sop",   s_out_sop, 64'(i == 0));
         chk("saf_eop",   s_out_eop, 64'(i == 4));
         step();
      end
      chk("saf_done_valid", s_out_valid, 0);
      chk("saf_pkt0",       s_pkt_count, 0);
      chk("saf_fill0",      s_fill_level, 0);

      // ---------------- store-and-forward: oversize ----------------
      s_out_ready = 0;
      for (int i = 0; i < 16; i++) begin
         s_in_valid = 1; s_in_data = DW'(12'h200 + i); s_in_sop = (i == 0); s_in_eop = 0;
         step();
         chk("ovs_no_pulse", s_oversize, 0);
      end
      s_in_valid = 0; s_in_sop = 0;
      chk("ovs_full_valid", s_out_valid, 0);
      chk("ovs_full_ready", s_in_ready, 0);
      step();
      chk("ovs_pulse",      s_oversize, 1);
      chk("ovs_valid",      s_out_valid, 1);
      chk("ovs_head",       s_out_data, 42'h200);
      step();
      chk("ovs_pulse_end",  s_oversize, 0);
      s_out_ready = 1;
      for (int i = 0; i < 16; i++) begin
         chk("ovs_drain_data", s_out_data, 64'(12'h200 + i));
         chk("ovs_drain_valid", s_out_valid, 1);
         chk("ovs_once", s_oversize, 0);
         step();
      end
      chk("ovs_empty_valid", s_out_valid, 0);
      s_in_valid = 1; s_in_data = 42'h2FF; s_in_eop = 1;
      step();
      s_in_valid = 0; s_in_eop = 0;
      step();
      chk("ovs_tail_valid", s_out_valid, 1);
      chk("ovs_tail_data",  s_out_data, 42'h2FF);
      chk("ovs_tail_eop",   s_out_eop, 1);
      step();                                  // pop eop: draining clears
      chk("ovs_tail_gone",  s_out_valid, 0);
      chk("ovs_pkt0",       s_pkt_count, 0);
      s_in_valid = 1; s_in_data = 42'h300; s_in_sop = 1;
      step();
      s_in_valid = 0; s_in_sop = 0;
      step();
      step();
      chk("ovs_held_again", s_out_valid, 0);
      chk("ovs_held_fill",  s_fill_level, 1);

      // ---------------- asynchronous reset mid-packet ----------------
      #3;
      reset_n = 1'b0;
      #1;
      chk("arst_fill",   s_fill_level, 0);
      chk("arst_pkt",    s_pkt_count, 0);
      chk("arst_ready",  s_in_ready, 1);
      chk("arst_valid",  s_out_valid, 0);
      chk("arst_ae",     s_almost_empty, 1);
      step();
      reset_n = 1'b1;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   // Global guard so the run always ends.
   initial begin
      #500000;
      $display("FAIL watchdog expired observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
`default_nettype wire
